uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with a write-side FIFO: software/MCU bus writes bytes, block serialises

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and baud defaults.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // 100 MHz system clock at 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Callers zero-extend the payload, which leaves its XOR unchanged
   function automatic logic frame_parity(input logic [8:0] data, input int mode);
      return (mode == PARITY_ODD) ? ~(^data) : ^data;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty, occupancy count and a dropped-write pulse.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_accept;
   logic             rd_accept;
   logic [LVL_W-1:0] level_next;

   // Acceptance uses the registered full flag, so a same-cycle pop never rescues a write
   assign wr_accept  = wr_en && !full;
   assign rd_accept  = rd_en && !empty;
   assign level_next = level + LVL_W'(wr_accept) - LVL_W'(rd_accept);
   assign rd_data    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level    <= level_next;
         full     <= (level_next == LVL_W'(DEPTH));
         empty    <= (level_next == '0);
         overflow <= wr_en && full;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes queued in a FIFO are sent LSB-first as
// START|DATA|[PARITY]|STOP frames, back-to-back while data remains.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PARITY_NONE,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_wr_en,
   input  logic [DATA_BITS-1:0]          tx_data_in,
   output logic                          tx_full,
   output logic                          tx_empty,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level,
   output logic                          tx_overflow,
   output logic                          tx_done,
   output logic                          tx_busy,
   output logic                          tx_serial_out
);

   localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $fatal(1, "uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
      $fatal(1, "uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $fatal(1, "uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $fatal(1, "uart_tx_fifo: CLKS_PER_BIT must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
   end

   tx_state_t            state;
   tx_state_t            state_next;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] fifo_head;
   logic                 parity_bit;
   logic                 fifo_pop;
   logic                 bit_end;
   logic                 done_next;
   logic                 line_next;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (tx_wr_en),
      .wr_data  (tx_data_in),
      .rd_en    (fifo_pop),
      .rd_data  (fifo_head),
      .full     (tx_full),
      .empty    (tx_empty),
      .level    (tx_level),
      .overflow (tx_overflow)
   );

   assign bit_end = (baud_cnt == BAUD_LAST);
   assign tx_busy = (state != ST_IDLE) || !tx_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      fifo_pop   = 1'b0;
      done_next  = 1'b0;
      line_next  = 1'b1;
      case (state)
         ST_IDLE: begin
            if (!tx_empty) begin
               fifo_pop   = 1'b1;
               state_next = ST_START;
            end
         end
         ST_START: begin
            line_next = 1'b0;
            if (bit_end) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            line_next = shift_reg[0];
            if (bit_end && bit_cnt == DATA_LAST) begin
               state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            line_next = parity_bit;
            if (bit_end) begin
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            // Chain straight into the next frame when more data is queued
            if (bit_end && bit_cnt == STOP_LAST) begin
               done_next = 1'b1;
               if (!tx_empty) begin
                  fifo_pop   = 1'b1;
                  state_next = ST_START;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The line is registered from the current state, so it trails the state by one clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt      <= '0;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         parity_bit    <= 1'b0;
         tx_serial_out <= 1'b1;
         tx_done       <= 1'b0;
      end else begin
         baud_cnt <= (state == ST_IDLE || bit_end) ? '0 : baud_cnt + BAUD_W'(1);
         if (state_next != state) begin
            bit_cnt <= '0;
         end else if (bit_end) begin
            bit_cnt <= bit_cnt + 4'd1;
         end
         if (fifo_pop) begin
            shift_reg  <= fifo_head;
            parity_bit <= frame_parity(9'(fifo_head), PARITY);
         end else if (state == ST_DATA && bit_end) begin
            shift_reg <= shift_reg >> 1;
         end
         tx_serial_out <= line_next;
         tx_done       <= done_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame formats, latency, FIFO burst/overflow and mid-frame reset.
module tb_uart_tx_fifo;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst;

   logic       a_wr_en, a_full, a_empty, a_overflow, a_done, a_busy, a_ser;
   logic [7:0] a_data;
   logic [4:0] a_level;
   logic       b_wr_en, b_full, b_empty, b_overflow, b_done, b_busy, b_ser;
   logic [7:0] b_data;
   logic [2:0] b_level;
   logic       c_wr_en, c_full, c_empty, c_overflow, c_done, c_busy, c_ser;
   logic [7:0] c_data;
   logic [2:0] c_level;
   logic       d_wr_en, d_full, d_empty, d_overflow, d_done, d_busy, d_ser;
   logic [6:0] d_data;
   logic [2:0] d_level;

   int   checks = 0;
   int   errors = 0;
   int   sel = 0;
   int   cyc_cnt = 0;
   int   done_cnt = 0;
   int   last_done_cyc = 0;
   logic mon_line;
   logic mon_done;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
      .clk(clk), .rst(rst), .tx_wr_en(a_wr_en), .tx_data_in(a_data), .tx_full(a_full),
      .tx_empty(a_empty), .tx_level(a_level), .tx_overflow(a_overflow), .tx_done(a_done),
      .tx_busy(a_busy), .tx_serial_out(a_ser));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
      .clk(clk), .rst(rst), .tx_wr_en(b_wr_en), .tx_data_in(b_data), .tx_full(b_full),
      .tx_empty(b_empty), .tx_level(b_level), .tx_overflow(b_overflow), .tx_done(b_done),
      .tx_busy(b_busy), .tx_serial_out(b_ser));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8o2 (
      .clk(clk), .rst(rst), .tx_wr_en(c_wr_en), .tx_data_in(c_data), .tx_full(c_full),
      .tx_empty(c_empty), .tx_level(c_level), .tx_overflow(c_overflow), .tx_done(c_done),
      .tx_busy(c_busy), .tx_serial_out(c_ser));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7n1 (
      .clk(clk), .rst(rst), .tx_wr_en(d_wr_en), .tx_data_in(d_data), .tx_full(d_full),
      .tx_empty(d_empty), .tx_level(d_level), .tx_overflow(d_overflow), .tx_done(d_done),
      .tx_busy(d_busy), .tx_serial_out(d_ser));

   always_comb begin
      mon_line = a_ser;
      mon_done = a_done;
      case (sel)
         1: begin mon_line = b_ser; mon_done = b_done; end
         2: begin mon_line = c_ser; mon_done = c_done; end
         3: begin mon_line = d_ser; mon_done = d_done; end
         default: begin mon_line = a_ser; mon_done = a_done; end
      endcase
   end

   // Counts done pulses of the selected instance and remembers when the last one was seen
   always @(negedge clk) begin
      cyc_cnt = cyc_cnt + 1;
      if (mon_done) begin
         done_cnt      = done_cnt + 1;
         last_done_cyc = cyc_cnt;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input int inst, input logic en, input logic [8:0] data);
      case (inst)
         1: begin b_wr_en = en; b_data = data[7:0]; end
         2: begin c_wr_en = en; c_data = data[7:0]; end
         3: begin d_wr_en = en; d_data = data[6:0]; end
         default: begin a_wr_en = en; a_data = data[7:0]; end
      endcase
   endtask

   task automatic write_byte(input int inst, input logic [8:0] data);
      apply_stimulus(inst, 1'b1, data);
      tick();
      apply_stimulus(inst, 1'b0, 9'h000);
   endtask

   // Entered just after a frame's first low edge; leaves at the next frame boundary
   task automatic check_bits(input string tag, input logic [15:0] exp, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ticks(CPB / 2);
         check_output($sformatf("%s bit%0d", tag, i), {31'd0, mon_line}, {31'd0, exp[i]});
         ticks(CPB - CPB / 2);
      end
   endtask

   // Entered just after the write edge of a byte into an idle transmitter
   task automatic check_frame(input string tag, input logic [15:0] exp, input int nbits);
      int done0;
      int wr_cyc;
      done0  = done_cnt;
      wr_cyc = cyc_cnt;
      check_output({tag, " line_pre"}, {31'd0, mon_line}, 32'd1);
      tick();
      check_output({tag, " line_k1"}, {31'd0, mon_line}, 32'd1);
      tick();
      check_output({tag, " line_k2"}, {31'd0, mon_line}, 32'd0);
      check_bits(tag, exp, nbits);
      check_output({tag, " done_count"}, done_cnt - done0, 32'd1);
      check_output({tag, " done_cycle"}, last_done_cyc - wr_cyc, nbits * CPB + 2);
      check_output({tag, " line_after"}, {31'd0, mon_line}, 32'd1);
   endtask

   initial begin
      int done0;
      rst = 1'b1;
      a_wr_en = 1'b0; a_data = '0;
      b_wr_en = 1'b0; b_data = '0;
      c_wr_en = 1'b0; c_data = '0;
      d_wr_en = 1'b0; d_data = '0;
      ticks(3);

      check_output("rst line",     {31'd0, a_ser},      32'd1);
      check_output("rst empty",    {31'd0, a_empty},    32'd1);
      check_output("rst full",     {31'd0, a_full},     32'd0);
      check_output("rst level",    {27'd0, a_level},    32'd0);
      check_output("rst overflow", {31'd0, a_overflow}, 32'd0);
      check_output("rst done",     {31'd0, a_done},     32'd0);
      check_output("rst busy",     {31'd0, a_busy},     32'd0);
      rst = 1'b0;
      ticks(2);

      sel = 0;
      write_byte(0, 9'h041);
      check_output("8n1 busy", {31'd0, a_busy}, 32'd1);
      check_frame("8n1_41", {6'b0, 1'b1, 8'h41, 1'b0}, 10);
      check_output("8n1 busy_end", {31'd0, a_busy}, 32'd0);
      check_output("8n1 empty_end", {31'd0, a_empty}, 32'd1);

      sel = 1;
      ticks(2);
      write_byte(1, 9'h041);
      check_frame("8e1_41", {5'b0, 1'b1, 1'b0, 8'h41, 1'b0}, 11);

      sel = 2;
      ticks(2);
      write_byte(2, 9'h041);
      check_frame("8o2_41", {4'b0, 2'b11, 1'b1, 8'h41, 1'b0}, 12);

      sel = 3;
      ticks(2);
      write_byte(3, 9'h055);
      check_frame("7n1_55", {7'b0, 1'b1, 7'h55, 1'b0}, 9);

      // Burst: one byte in flight, then 17 writes into the 16-deep FIFO
      sel = 0;
      ticks(2);
      done0 = done_cnt;
      write_byte(0, 9'h0FF);
      tick();
      for (int i = 0; i < 17; i++) begin
         apply_stimulus(0, 1'b1, 9'(i));
         tick();
         if (i < 16) begin
            check_output($sformatf("burst level%0d", i), {27'd0, a_level}, i + 1);
            check_output($sformatf("burst ovf%0d", i), {31'd0, a_overflow}, 32'd0);
         end else begin
            check_output("burst ovf16", {31'd0, a_overflow}, 32'd1);
            check_output("burst level_full", {27'd0, a_level}, 32'd16);
         end
         if (i == 15) begin
            check_output("burst full", {31'd0, a_full}, 32'd1);
         end
      end
      apply_stimulus(0, 1'b0, 9'h000);
      tick();
      check_output("burst ovf_end", {31'd0, a_overflow}, 32'd0);
      ticks(23);
      for (int m = 0; m < 16; m++) begin
         check_output($sformatf("burst start%0d", m), {31'd0, mon_line}, 32'd0);
         check_output($sformatf("burst lvl_at%0d", m), {27'd0, a_level}, 15 - m);
         check_bits($sformatf("burst_f%0d", m), {6'b0, 1'b1, 8'(m), 1'b0}, 10);
      end
      check_output("burst level_end", {27'd0, a_level}, 32'd0);
      check_output("burst busy_end", {31'd0, a_busy}, 32'd0);
      check_output("burst line_end", {31'd0, mon_line}, 32'd1);
      check_output("burst done_total", done_cnt - done0, 32'd17);

      // Reset in the middle of a data bit with three bytes queued
      ticks(2);
      write_byte(0, 9'h0A5);
      write_byte(0, 9'h001);
      write_byte(0, 9'h002);
      write_byte(0, 9'h003);
      check_output("rstmid level", {27'd0, a_level}, 32'd3);
      ticks(9);
      check_output("rstmid line_low", {31'd0, a_ser}, 32'd0);
      done0 = done_cnt;
      rst = 1'b1;
      #1;
      check_output("rstmid line", {31'd0, a_ser}, 32'd1);
      check_output("rstmid level0", {27'd0, a_level}, 32'd0);
      check_output("rstmid empty", {31'd0, a_empty}, 32'd1);
      check_output("rstmid busy", {31'd0, a_busy}, 32'd0);
      ticks(2);
      rst = 1'b0;
      ticks(3);
      check_output("rstmid no_done", done_cnt - done0, 32'd0);
      check_output("rstmid line_idle", {31'd0, a_ser}, 32'd1);
      write_byte(0, 9'h03C);
      check_frame("8n1_3c", {6'b0, 1'b1, 8'h3C, 1'b0}, 10);

      // Write lands on the very clock the FSM pops from a full FIFO
      ticks(2);
      write_byte(0, 9'h011);
      tick();
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(0, 1'b1, 9'(i));
         tick();
      end
      apply_stimulus(0, 1'b0, 9'h000);
      check_output("popfull full", {31'd0, a_full}, 32'd1);
      check_output("popfull level16", {27'd0, a_level}, 32'd16);
      ticks(23);
      check_output("popfull done_before", {31'd0, a_done}, 32'd0);
      apply_stimulus(0, 1'b1, 9'h0EE);
      tick();
      apply_stimulus(0, 1'b0, 9'h000);
      check_output("popfull done", {31'd0, a_done}, 32'd1);
      check_output("popfull overflow", {31'd0, a_overflow}, 32'd1);
      check_output("popfull level15", {27'd0, a_level}, 32'd15);
      check_output("popfull not_full", {31'd0, a_full}, 32'd0);
      tick();
      check_output("popfull ovf_end", {31'd0, a_overflow}, 32'd0);
      check_output("popfull level_hold", {27'd0, a_level}, 32'd15);
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      tick();
      check_output("final level", {27'd0, a_level}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
